// File: rtl/gate_array_regs.sv
// Gate array CPU register file and 300 Hz raster interrupt generator.
// Outputs feed the video stage directly; all state is registered on clk.
module gate_array_regs #(
  parameter int unsigned INT_LINES   = 52,
  parameter int unsigned INT_THRESH  = 32,
  parameter int unsigned VSYNC_DELAY = 2,
  parameter logic [1:0]  INIT_MODE   = 2'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_data,
  input  logic        int_ack,
  input  logic        hsync,
  input  logic        vsync,
  output logic [1:0]  mode,
  output logic [4:0]  border_color,
  output logic [79:0] colors,
  output logic        n_int,
  output logic        lower_rom_en,
  output logic        upper_rom_en,
  output logic [2:0]  ram_config
);

  localparam logic [5:0] IntLast   = 6'(INT_LINES - 1);
  localparam logic [5:0] IntThresh = 6'(INT_THRESH);
  localparam logic [3:0] VsLast    = 4'(VSYNC_DELAY - 1);

  logic [1:0]  mode_q, mode_d, mode_pend_q, mode_pend_d;
  logic [4:0]  border_q, border_d, pen_sel_q, pen_sel_d;
  logic [79:0] colors_q, colors_d;
  logic [5:0]  int_cnt_q, int_cnt_d;
  logic        int_q, int_d;
  logic        lrom_q, lrom_d, urom_q, urom_d;
  logic [2:0]  ram_cfg_q, ram_cfg_d;
  logic        vs_armed_q, vs_armed_d;
  logic [3:0]  vs_cnt_q, vs_cnt_d;
  logic        hsync_q, vsync_q;

  logic sel, hs_rise, hs_fall, vs_rise, resync;
  logic unused_bits;

  assign sel     = io_wr && (io_addr[15:14] == 2'b01);
  assign hs_rise = hsync && !hsync_q;
  assign hs_fall = !hsync && hsync_q;
  assign vs_rise = vsync && !vsync_q;
  assign resync  = hs_fall && vs_armed_q && (vs_cnt_q == VsLast);
  assign unused_bits = ^{io_addr[13:0], io_data[5]};

  always_comb begin
    mode_d      = mode_q;
    mode_pend_d = mode_pend_q;
    border_d    = border_q;
    pen_sel_d   = pen_sel_q;
    colors_d    = colors_q;
    int_cnt_d   = int_cnt_q;
    int_d       = int_q;
    lrom_d      = lrom_q;
    urom_d      = urom_q;
    ram_cfg_d   = ram_cfg_q;
    vs_armed_d  = vs_armed_q;
    vs_cnt_d    = vs_cnt_q;

    if (sel) begin
      unique case (io_data[7:6])
        2'b00: pen_sel_d = io_data[4] ? 5'h10 : {1'b0, io_data[3:0]};
        2'b01: begin
          if (pen_sel_q[4]) border_d = io_data[4:0];
          else colors_d[{3'b000, pen_sel_q[3:0]} * 7'd5 +: 5] = io_data[4:0];
        end
        2'b10: begin
          mode_pend_d = io_data[1:0];
          lrom_d      = !io_data[2];
          urom_d      = !io_data[3];
        end
        2'b11: ram_cfg_d = io_data[2:0];
      endcase
    end

    // Mode only changes at the start of a line.
    if (hs_rise) mode_d = mode_pend_q;

    if (vs_rise) begin
      vs_armed_d = 1'b1;
      vs_cnt_d   = '0;
    end else if (hs_fall && vs_armed_q) begin
      if (resync) vs_armed_d = 1'b0;
      else vs_cnt_d = vs_cnt_q + 4'd1;
    end

    // Later assignments win: ack < counter raise < bit4 clear.
    if (int_ack) begin
      int_d        = 1'b0;
      int_cnt_d[5] = 1'b0;
    end
    if (hs_fall) begin
      if (resync) begin
        if (int_cnt_q >= IntThresh) int_d = 1'b1;
        int_cnt_d = '0;
      end else if (int_cnt_q == IntLast) begin
        int_cnt_d = '0;
        int_d     = 1'b1;
      end else begin
        int_cnt_d = int_cnt_q + 6'd1;
      end
    end
    if (sel && (io_data[7:6] == 2'b10) && io_data[4]) begin
      int_cnt_d = '0;
      int_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q      <= INIT_MODE;
      mode_pend_q <= INIT_MODE;
      border_q    <= '0;
      pen_sel_q   <= '0;
      colors_q    <= '0;
      int_cnt_q   <= '0;
      int_q       <= 1'b0;
      lrom_q      <= 1'b1;
      urom_q      <= 1'b1;
      ram_cfg_q   <= '0;
      vs_armed_q  <= 1'b0;
      vs_cnt_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      mode_pend_q <= mode_pend_d;
      border_q    <= border_d;
      pen_sel_q   <= pen_sel_d;
      colors_q    <= colors_d;
      int_cnt_q   <= int_cnt_d;
      int_q       <= int_d;
      lrom_q      <= lrom_d;
      urom_q      <= urom_d;
      ram_cfg_q   <= ram_cfg_d;
      vs_armed_q  <= vs_armed_d;
      vs_cnt_q    <= vs_cnt_d;
      hsync_q     <= hsync;
      vsync_q     <= vsync;
    end
  end

  assign mode         = mode_q;
  assign border_color = border_q;
  assign colors       = colors_q;
  assign n_int        = !int_q;
  assign lower_rom_en = lrom_q;
  assign upper_rom_en = urom_q;
  assign ram_config   = ram_cfg_q;

endmodule

// File: tb/tb_gate_array_regs.sv
// Directed self-checking bench for gate_array_regs.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_gate_array_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = '0;
  logic [7:0]  io_data = '0;
  logic        int_ack = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [1:0]  mode;
  logic [4:0]  border_color;
  logic [79:0] colors;
  logic        n_int;
  logic        lower_rom_en;
  logic        upper_rom_en;
  logic [2:0]  ram_config;

  int errors = 0;
  int checks = 0;

  gate_array_regs dut (
    .clk          (clk),
    .reset        (reset),
    .io_wr        (io_wr),
    .io_addr      (io_addr),
    .io_data      (io_data),
    .int_ack      (int_ack),
    .hsync        (hsync),
    .vsync        (vsync),
    .mode         (mode),
    .border_color (border_color),
    .colors       (colors),
    .n_int        (n_int),
    .lower_rom_en (lower_rom_en),
    .upper_rom_en (upper_rom_en),
    .ram_config   (ram_config)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    io_wr   = 1'b1;
    io_addr = a;
    io_data = d;
    tick();
    io_wr = 1'b0;
  endtask

  // One cycle high, one cycle low: the counter has stepped when this returns.
  task automatic hpulse(input int n);
    for (int i = 0; i < n; i++) begin
      hsync = 1'b1;
      tick();
      hsync = 1'b0;
      tick();
    end
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mode, border_color, n_int, lower_rom_en, upper_rom_en, ram_config} !==
        {2'd1, 5'd0, 1'b1, 1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: mode=%0d border=%0d n_int=%b lrom=%b urom=%b ram=%0d",
               mode, border_color, n_int, lower_rom_en, upper_rom_en, ram_config);
    end
    checks++;
    if (colors !== 80'd0) begin
      errors++;
      $display("FAIL reset_colors: got %h want 0", colors);
    end
  endtask

  task automatic test_inks();
    logic [79:0] exp_colors;
    exp_colors = 80'd0;
    exp_colors[19:15] = 5'h0A;
    do_reset();
    wr(16'h7F00, 8'h03);
    wr(16'h7F00, 8'h4A);
    wr(16'h7F00, 8'h10);
    wr(16'h7F00, 8'h54);
    checks++;
    if (colors !== exp_colors) begin
      errors++;
      $display("FAIL pen3_ink: got %h want %h", colors, exp_colors);
    end
    checks++;
    if (border_color !== 5'h14) begin
      errors++;
      $display("FAIL border_ink: got %h want 14", border_color);
    end
    // Pen 15 and pen 0 at the ends of the table, border untouched.
    wr(16'h7F00, 8'h0F);
    wr(16'h7F00, 8'h5F);
    wr(16'h7F00, 8'h00);
    wr(16'h7F00, 8'h41);
    exp_colors[79:75] = 5'h1F;
    exp_colors[4:0]   = 5'h01;
    checks++;
    if (colors !== exp_colors || border_color !== 5'h14) begin
      errors++;
      $display("FAIL pen_edges: got %h/%h want %h/14", colors, border_color, exp_colors);
    end
  endtask

  task automatic test_mode_rom();
    do_reset();
    wr(16'h7F00, 8'h8C);
    checks++;
    if ({lower_rom_en, upper_rom_en, mode} !== {1'b0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL rom_after_write: lrom=%b urom=%b mode=%0d want 0 0 1",
               lower_rom_en, upper_rom_en, mode);
    end
    tick();
    tick();
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL mode_midline: got %0d want 1", mode);
    end
    hsync = 1'b1;
    tick();
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL mode_at_hsync: got %0d want 0", mode);
    end
    hsync = 1'b0;
    tick();
    wr(16'h7F00, 8'hC5);
    checks++;
    if (ram_config !== 3'd5) begin
      errors++;
      $display("FAIL ram_config: got %0d want 5", ram_config);
    end
  endtask

  task automatic test_int_count();
    do_reset();
    hpulse(51);
    checks++;
    if (n_int !== 1'b1 || dut.int_cnt_q !== 6'd51) begin
      errors++;
      $display("FAIL int_51: n_int=%b cnt=%0d want 1 51", n_int, dut.int_cnt_q);
    end
    hpulse(1);
    checks++;
    if (n_int !== 1'b0 || dut.int_cnt_q !== 6'd0) begin
      errors++;
      $display("FAIL int_52: n_int=%b cnt=%0d want 0 0", n_int, dut.int_cnt_q);
    end
    hpulse(3);
    checks++;
    if (n_int !== 1'b0) begin
      errors++;
      $display("FAIL int_held: n_int=%b want 0", n_int);
    end
    ack();
    checks++;
    if (n_int !== 1'b1 || dut.int_cnt_q !== 6'd3) begin
      errors++;
      $display("FAIL int_ack: n_int=%b cnt=%0d want 1 3", n_int, dut.int_cnt_q);
    end
    hpulse(48);
    checks++;
    if (n_int !== 1'b1) begin
      errors++;
      $display("FAIL int_second_early: n_int=%b want 1", n_int);
    end
    hpulse(1);
    checks++;
    if (n_int !== 1'b0 || dut.int_cnt_q !== 6'd0) begin
      errors++;
      $display("FAIL int_second: n_int=%b cnt=%0d want 0 0", n_int, dut.int_cnt_q);
    end
    ack();
  endtask

  task automatic test_vsync();
    do_reset();
    hpulse(40);
    vsync = 1'b1;
    tick();
    hpulse(1);
    vsync = 1'b0;
    checks++;
    if (n_int !== 1'b1 || dut.int_cnt_q !== 6'd41) begin
      errors++;
      $display("FAIL vs_first_edge: n_int=%b cnt=%0d want 1 41", n_int, dut.int_cnt_q);
    end
    hpulse(1);
    checks++;
    if (n_int !== 1'b0 || dut.int_cnt_q !== 6'd0) begin
      errors++;
      $display("FAIL vs_resync_high: n_int=%b cnt=%0d want 0 0", n_int, dut.int_cnt_q);
    end
    ack();
    hpulse(10);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    hpulse(2);
    checks++;
    if (n_int !== 1'b1 || dut.int_cnt_q !== 6'd0) begin
      errors++;
      $display("FAIL vs_resync_low: n_int=%b cnt=%0d want 1 0", n_int, dut.int_cnt_q);
    end
    hpulse(3);
    checks++;
    if (dut.int_cnt_q !== 6'd3) begin
      errors++;
      $display("FAIL vs_disarmed: cnt=%0d want 3", dut.int_cnt_q);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hpulse(51);
    hsync = 1'b1;
    tick();
    hsync   = 1'b0;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++;
    if (n_int !== 1'b0) begin
      errors++;
      $display("FAIL raise_beats_ack: n_int=%b want 0", n_int);
    end
    ack();
    hpulse(51);
    hsync = 1'b1;
    tick();
    hsync   = 1'b0;
    int_ack = 1'b1;
    io_wr   = 1'b1;
    io_addr = 16'h7F00;
    io_data = 8'h90;
    tick();
    int_ack = 1'b0;
    io_wr   = 1'b0;
    checks++;
    if (n_int !== 1'b1 || dut.int_cnt_q !== 6'd0) begin
      errors++;
      $display("FAIL clear_beats_raise: n_int=%b cnt=%0d want 1 0", n_int, dut.int_cnt_q);
    end
    hpulse(20);
    wr(16'h7F00, 8'h90);
    checks++;
    if (dut.int_cnt_q !== 6'd0) begin
      errors++;
      $display("FAIL bit4_clear_cnt: cnt=%0d want 0", dut.int_cnt_q);
    end
  endtask

  task automatic test_ignore_and_reset();
    do_reset();
    wr(16'hBC00, 8'h8C);
    wr(16'hBC00, 8'hC7);
    wr(16'h3F00, 8'h10);
    wr(16'h3F00, 8'h5F);
    checks++;
    if ({lower_rom_en, upper_rom_en, ram_config, border_color} !== {1'b1, 1'b1, 3'd0, 5'd0}) begin
      errors++;
      $display("FAIL unselected_write: lrom=%b urom=%b ram=%0d border=%0d want 1 1 0 0",
               lower_rom_en, upper_rom_en, ram_config, border_color);
    end
    wr(16'h7F00, 8'h4F);
    wr(16'h7F00, 8'h80);
    hpulse(40);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    hpulse(1);
    do_reset();
    checks++;
    if ({mode, n_int, colors} !== {2'd1, 1'b1, 80'd0}) begin
      errors++;
      $display("FAIL mid_reset: mode=%0d n_int=%b colors=%h want 1 1 0", mode, n_int, colors);
    end
    hpulse(1);
    checks++;
    if ({mode, n_int, dut.int_cnt_q} !== {2'd1, 1'b1, 6'd1}) begin
      errors++;
      $display("FAIL reset_discard: mode=%0d n_int=%b cnt=%0d want 1 1 1",
               mode, n_int, dut.int_cnt_q);
    end
  endtask

  initial begin
    test_reset();
    test_inks();
    test_mode_rom();
    test_int_count();
    test_vsync();
    test_back_to_back();
    test_ignore_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
